// File: rtl/pbus_addr_gen.sv
// pbus_addr_gen: arbitrates C/S tile-address requests onto the multiplexed P bus with framed latch strobes
module pbus_addr_gen #(
  parameter int SETUP = 1,
  parameter int PULSE = 2,
  parameter int HOLD  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] c_addr,
  input  logic        c_valid,
  output logic        c_ready,
  input  logic [15:0] s_addr,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [23:0] p,
  output logic        pck1b,
  output logic        pck2b,
  output logic        c_done,
  output logic        s_done,
  output logic        busy
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;
  localparam logic [3:0] SETUP_LD = 4'(SETUP > 0 ? SETUP - 1 : 0);
  localparam logic [3:0] PULSE_LD = 4'(PULSE - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD > 0 ? HOLD - 1 : 0);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [23:0] p_q, p_d;
  logic        pck1b_q, pck1b_d, pck2b_q, pck2b_d;
  logic        c_done_q, c_done_d, s_done_q, s_done_d;
  logic        busy_q, busy_d;
  logic        idle, c_win, s_win, cnt_end;
  // Arbitration, phase sequencing and registered output values; sel/last are 1 for C
  always_comb begin
    idle    = state_q == ST_IDLE;
    cnt_end = cnt_q == 4'd0;
    c_win   = c_valid && (!s_valid || !last_q);
    s_win   = s_valid && !c_win;
    c_ready = idle && !rst && !(c_valid && s_valid && last_q);
    s_ready = idle && !rst && !(c_valid && s_valid && !last_q);
    state_d = state_q;
    cnt_d   = cnt_end ? cnt_q : cnt_q - 4'd1;
    sel_d   = sel_q;
    last_d  = last_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: if (c_win || s_win) begin
        sel_d   = c_win;
        last_d  = c_win;
        p_d     = c_win ? c_addr : {8'h00, s_addr};
        state_d = SETUP == 0 ? ST_STROBE : ST_SETUP;
        cnt_d   = SETUP == 0 ? PULSE_LD : SETUP_LD;
      end
      ST_SETUP: if (cnt_end) begin
        state_d = ST_STROBE;
        cnt_d   = PULSE_LD;
      end
      ST_STROBE: if (cnt_end) begin
        state_d = ST_HOLD;
        cnt_d   = HOLD_LD;
      end
      ST_HOLD: state_d = cnt_end ? ST_IDLE : ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
    pck1b_d  = !(state_d == ST_STROBE && sel_d);
    pck2b_d  = !(state_d == ST_STROBE && !sel_d);
    c_done_d = state_q == ST_STROBE && state_d == ST_HOLD && sel_q;
    s_done_d = state_q == ST_STROBE && state_d == ST_HOLD && !sel_q;
    busy_d   = state_d != ST_IDLE;
  end
  // State and output registers; reset drops any slot in progress without a done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      sel_q    <= 1'b0;
      last_q   <= 1'b0;
      p_q      <= 24'h0;
      pck1b_q  <= 1'b1;
      pck2b_q  <= 1'b1;
      c_done_q <= 1'b0;
      s_done_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      p_q      <= p_d;
      pck1b_q  <= pck1b_d;
      pck2b_q  <= pck2b_d;
      c_done_q <= c_done_d;
      s_done_q <= s_done_d;
      busy_q   <= busy_d;
    end
  end
  assign p      = p_q;
  assign pck1b  = pck1b_q;
  assign pck2b  = pck2b_q;
  assign c_done = c_done_q;
  assign s_done = s_done_q;
  assign busy   = busy_q;
endmodule
